// File: rtl/rd_stream_bridge.sv
// ---------------------------------------------------------------------------
// rd_stream_bridge
//
// Read-domain drain stage placed directly after the async FIFO. It drives the
// FIFO read enable, soaks up the FIFO's one-cycle read latency in a 2-entry
// output buffer (head/tail), and presents the words as a valid/ready stream
// at up to one word per clock. It also counts completed handshakes and
// supports a synchronous flush of buffered and in-flight words.
//
// Parameters
//   data_width : width of the FIFO word and of the stream data
//   cnt_width  : width of the delivered-word counter (wraps)
//
// Ports
//   r_clk      in   read-domain clock, the only clock
//   rrst_n     in   asynchronous active-low reset, released synchronously
//   fifo_empty in   FIFO empty flag (read domain)
//   fifo_data  in   FIFO read data, valid the cycle after an accepted read
//   fifo_r_en  out  FIFO read enable (never high while fifo_empty is high)
//   m_data     out  stream data, always the buffer head
//   m_valid    out  stream valid, high whenever the buffer is non-empty
//   m_ready    in   stream ready from the consumer
//   flush      in   drop buffered words and the in-flight word this cycle
//   rd_count   out  number of completed stream handshakes, wraps
// ---------------------------------------------------------------------------
module rd_stream_bridge #(
  parameter int data_width = 8,
  parameter int cnt_width  = 16
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [cnt_width-1:0]  rd_count
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                  run_q;     // set on the first edge after reset release
  logic [1:0]            occ_q;     // buffer occupancy, 0..2
  logic [1:0]            occ_d;
  logic                  infl_q;    // a FIFO read was issued last cycle
  logic [data_width-1:0] head_q;
  logic [data_width-1:0] head_d;
  logic [data_width-1:0] tail_q;
  logic [data_width-1:0] tail_d;
  logic [cnt_width-1:0]  cnt_q;
  logic [cnt_width-1:0]  cnt_d;

  // -------------------------------------------------------------------------
  // Handshake, read request and capture decode
  // -------------------------------------------------------------------------
  logic       pop;
  logic       capture;
  logic [1:0] occ_ap;   // occupancy after this cycle's pop
  logic [2:0] fill_w;   // words held or owed after this cycle's pop

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;
  assign pop     = m_valid & m_ready;

  assign occ_ap  = occ_q - {1'b0, pop};
  assign fill_w  = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

  // Issue a read only if the word it returns next cycle is guaranteed a free
  // slot: buffered + in-flight, minus what leaves now, must be at most one.
  // run_q keeps the request low until the first edge after reset release so
  // the FIFO never sees a read during or straight out of reset.
  assign fifo_r_en = run_q & ~fifo_empty & ~flush & (fill_w <= 3'd1);

  // The word returned for last cycle's read is taken unless a flush drops it.
  assign capture = infl_q & ~flush;

  // -------------------------------------------------------------------------
  // Buffer next state
  // -------------------------------------------------------------------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      // Popping a full buffer promotes the tail so order is preserved.
      if (pop && (occ_q == 2'd2)) begin
        head_d = tail_q;
      end
      // The incoming word lands in the first slot left free after the pop.
      if (capture) begin
        if (occ_ap == 2'd0) begin
          head_d = fifo_data;
        end else begin
          tail_d = fifo_data;
        end
      end
      occ_d = occ_ap + {1'b0, capture};
    end
  end

  assign cnt_d    = cnt_q + {{(cnt_width-1){1'b0}}, pop};
  assign rd_count = cnt_q;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      run_q  <= 1'b0;
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      run_q  <= 1'b1;
      occ_q  <= occ_d;
      infl_q <= fifo_r_en;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Design-error checks
  // -------------------------------------------------------------------------
  // A capture into a buffer that stays full after the pop would be lost.
  a_no_overflow : assert property (@(posedge r_clk) disable iff (!rrst_n)
    !(capture && (occ_ap == 2'd2)))
    else $error("rd_stream_bridge: output buffer overflow");

  a_occ_range : assert property (@(posedge r_clk) disable iff (!rrst_n)
    (occ_q != 2'd3))
    else $error("rd_stream_bridge: occupancy out of range");

  a_no_read_empty : assert property (@(posedge r_clk) disable iff (!rrst_n)
    !(fifo_r_en && fifo_empty))
    else $error("rd_stream_bridge: read issued to an empty FIFO");

endmodule

// File: tb/tb_rd_stream_bridge.sv
// ---------------------------------------------------------------------------
// tb_rd_stream_bridge
//
// Directed bench for rd_stream_bridge. A behavioural FIFO (array + pointers,
// one-cycle read latency) feeds the DUT. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rd_stream_bridge;

  logic        r_clk = 1'b0;
  logic        rrst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_r_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        flush;
  logic [15:0] rd_count;

  logic [7:0]  mem [0:69999];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int          n_chk  = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic        m_ready;
    logic        flush;
    logic        exp_ren;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [10];

  rd_stream_bridge #(.data_width(8), .cnt_width(16)) dut (
    .r_clk      (r_clk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush      (flush),
    .rd_count   (rd_count)
  );

  always #5 r_clk = ~r_clk;

  // Behavioural FIFO: a read accepted at an edge shows its word next cycle.
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge r_clk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      mem[wr_ptr] = 8'(base + j);
      wr_ptr      = wr_ptr + 1;
    end
  endtask

  task automatic next_cycle();
    @(posedge r_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge r_clk);
    if (rrst_n) check("ren_while_empty", 32'(fifo_r_en & fifo_empty), 32'd0);
  endtask

  // Accept n words expected as base, base+1, ...; optionally toggle m_ready
  // and optionally require one word per cycle after the first.
  task automatic collect(input logic [7:0] base, input int n, input int maxc,
                         input bit toggle, input bit chk_gap,
                         output int first_ren, output int first_vld);
    int k;
    k         = 0;
    first_ren = -1;
    first_vld = -1;
    flush     = 1'b0;
    for (int i = 0; i < maxc && k < n; i++) begin
      m_ready = toggle ? ((i % 2) == 0) : 1'b1;
      sample();
      if (fifo_r_en && first_ren < 0) first_ren = i;
      if (m_valid && m_ready) begin
        check($sformatf("data[%0d]", k), 32'(m_data), 32'(8'(base + k)));
        if (k == 0) first_vld = i;
        else if (chk_gap) check("no_bubble", 32'(i), 32'(first_vld + k));
        k++;
      end
      next_cycle();
    end
    check("collect_count", 32'(k), 32'(n));
  endtask

  task automatic wait_idle(input int maxc);
    int  idle;
    bit  done;
    idle    = 0;
    done    = 1'b0;
    m_ready = 1'b1;
    flush   = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      sample();
      if (!m_valid && !fifo_r_en && fifo_empty) idle++;
      else idle = 0;
      if (idle >= 2) done = 1'b1;
      next_cycle();
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  initial begin
    int fr;
    int fv;
    int ren_pulses;

    // Backpressure then release: four words 0xA0..0xA3, count starts at 5.
    //            rdy   fl    ren   vld   data   cnt
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd5};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd5};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd5};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd5};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd5};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 16'd5};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 16'd6};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 16'd7};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 16'd8};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd9};

    rrst_n  = 1'b1;
    m_ready = 1'b0;
    flush   = 1'b0;

    // Reset values
    #2 rrst_n = 1'b0;
    #1;
    check("rst_valid", 32'(m_valid),   32'd0);
    check("rst_data",  32'(m_data),    32'd0);
    check("rst_count", 32'(rd_count),  32'd0);
    check("rst_ren",   32'(fifo_r_en), 32'd0);
    @(posedge r_clk);
    @(posedge r_clk);
    #3 rrst_n = 1'b1;
    next_cycle();

    // Five words at full rate; the read seen in cycle i is accepted at the
    // following edge and the word is buffered one edge later.
    push(8'h11, 5);
    collect(8'h11, 5, 30, 1'b0, 1'b1, fr, fv);
    check("t1_first_ren", 32'(fr), 32'd0);
    check("t1_latency",   32'(fv), 32'(fr + 2));
    wait_idle(20);
    check("t1_count", 32'(rd_count), 32'd5);

    // Backpressure table
    ren_pulses = 0;
    for (int r = 0; r < 10; r++) begin
      m_ready = tbl[r].m_ready;
      flush   = tbl[r].flush;
      if (r == 0) push(8'hA0, 4);
      sample();
      if (r < 5 && fifo_r_en) ren_pulses++;
      check($sformatf("t2_ren[%0d]", r),   32'(fifo_r_en), 32'(tbl[r].exp_ren));
      check($sformatf("t2_valid[%0d]", r), 32'(m_valid),   32'(tbl[r].exp_valid));
      if (tbl[r].exp_valid)
        check($sformatf("t2_data[%0d]", r), 32'(m_data), 32'(tbl[r].exp_data));
      check($sformatf("t2_cnt[%0d]", r),   32'(rd_count),  32'(tbl[r].exp_cnt));
      next_cycle();
    end
    check("t2_ren_pulses", 32'(ren_pulses), 32'd2);
    wait_idle(20);

    // Sixteen words with m_ready toggling each cycle
    push(8'h30, 16);
    collect(8'h30, 16, 100, 1'b1, 1'b0, fr, fv);
    wait_idle(20);
    check("t3_count", 32'(rd_count), 32'd25);

    // Flush with one word buffered (0x50) and 0x51 in flight; the pop of 0x50
    // in the flush cycle still counts, 0x51 is dropped.
    push(8'h50, 5);
    m_ready = 1'b0;
    flush   = 1'b0;
    sample();
    check("t4_ren_c0", 32'(fifo_r_en), 32'd1);
    next_cycle();
    sample();
    check("t4_ren_c1",   32'(fifo_r_en), 32'd1);
    check("t4_valid_c1", 32'(m_valid),   32'd0);
    next_cycle();
    m_ready = 1'b1;
    flush   = 1'b1;
    sample();
    check("t4_valid_fl", 32'(m_valid),   32'd1);
    check("t4_data_fl",  32'(m_data),    32'h50);
    check("t4_ren_fl",   32'(fifo_r_en), 32'd0);
    next_cycle();
    m_ready = 1'b0;
    flush   = 1'b0;
    sample();
    check("t4_valid_after", 32'(m_valid),   32'd0);
    check("t4_ren_after",   32'(fifo_r_en), 32'd1);
    next_cycle();
    collect(8'h52, 3, 20, 1'b0, 1'b0, fr, fv);
    wait_idle(20);
    check("t4_count", 32'(rd_count), 32'd29);

    // Counter wrap: 29 + 65506 = 0xFFFF, then one more handshake
    push(8'h00, 65506);
    collect(8'h00, 65506, 66000, 1'b0, 1'b1, fr, fv);
    wait_idle(20);
    check("t5_count_max", 32'(rd_count), 32'hFFFF);
    push(8'h77, 1);
    collect(8'h77, 1, 10, 1'b0, 1'b0, fr, fv);
    wait_idle(20);
    check("t5_count_wrap", 32'(rd_count), 32'd0);

    // Reset mid-burst: 0x60 delivered, 0x61 buffered, 0x62 in flight when
    // reset hits; the FIFO keeps 0x63..0x65.
    push(8'h60, 6);
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      next_cycle();
    end
    #2 rrst_n = 1'b0;
    #1;
    check("t6_valid", 32'(m_valid),   32'd0);
    check("t6_data",  32'(m_data),    32'd0);
    check("t6_count", 32'(rd_count),  32'd0);
    check("t6_ren",   32'(fifo_r_en), 32'd0);
    @(posedge r_clk);
    @(posedge r_clk);
    #3 rrst_n = 1'b1;
    sample();
    check("t6_ren_release", 32'(fifo_r_en), 32'd0);
    next_cycle();
    collect(8'h63, 3, 20, 1'b0, 1'b0, fr, fv);
    wait_idle(20);
    check("t6_count_after", 32'(rd_count), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
